// File: rtl/button_bank_scheduler.sv
// Debounces a bank of raw buttons off one shared sample tick and funnels their
// press/release events through a round-robin arbiter onto one valid/ready port.
module button_bank_scheduler #(
  parameter int N_BTN        = 4,
  parameter int TICK_DIV     = 999_999,
  parameter int STABLE_TICKS = 3,
  localparam int IDW         = $clog2(N_BTN)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [N_BTN-1:0] noisy,
  output logic [N_BTN-1:0] debounced,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [IDW-1:0]   evt_id,
  output logic             evt_press,
  output logic             overrun,
  input  logic             clear_overrun
);

  localparam int PW = (TICK_DIV > 0) ? $clog2(TICK_DIV + 1) : 1;
  localparam int CW = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
  localparam logic [PW-1:0] PCNT_LAST = PW'(TICK_DIV);
  localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_TICKS - 1);

  logic [N_BTN-1:0] sync1_reg;
  logic [N_BTN-1:0] sync2_reg;
  logic [PW-1:0]    pcnt_reg;
  logic             tick;

  logic [N_BTN-1:0] deb_reg,   deb_next;
  logic [N_BTN-1:0] pend_reg,  pend_next;
  logic [N_BTN-1:0] ptype_reg, ptype_next;
  logic [N_BTN-1:0] ovr_set;
  logic [CW-1:0]    cnt_reg  [N_BTN];
  logic [CW-1:0]    cnt_next [N_BTN];

  logic [IDW-1:0]   ptr_reg;
  logic [IDW-1:0]   gnt_idx;
  logic [IDW-1:0]   cand;
  logic             gnt_any;
  logic             load;

  logic             evt_valid_reg;
  logic [IDW-1:0]   evt_id_reg;
  logic             evt_press_reg;
  logic             overrun_reg;

  assign tick = enable && (pcnt_reg == PCNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
      pcnt_reg  <= '0;
    end else begin
      sync1_reg <= noisy;
      sync2_reg <= sync1_reg;
      if (!enable || tick)
        pcnt_reg <= '0;
      else
        pcnt_reg <= pcnt_reg + PW'(1);
    end
  end

  // Per-channel stability counter; a channel that flips while its slot is
  // being granted keeps pend set with the new type and is not an overrun.
  generate
    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_chan
      logic mism;
      logic flip;
      logic take;

      assign mism = sync2_reg[gi] ^ deb_reg[gi];
      assign flip = tick && mism && (cnt_reg[gi] == CNT_LAST);
      assign take = load && (gnt_idx == IDW'(gi));

      assign cnt_next[gi]   = (!enable || (tick && (!mism || flip))) ? '0 :
                              tick ? cnt_reg[gi] + CW'(1) : cnt_reg[gi];
      assign deb_next[gi]   = flip ? sync2_reg[gi] : deb_reg[gi];
      assign ptype_next[gi] = flip ? sync2_reg[gi] : ptype_reg[gi];
      assign pend_next[gi]  = flip || (pend_reg[gi] && !take);
      assign ovr_set[gi]    = flip && pend_reg[gi] && !take;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_reg   <= '0;
      pend_reg  <= '0;
      ptype_reg <= '0;
      for (int i = 0; i < N_BTN; i++) cnt_reg[i] <= '0;
    end else begin
      deb_reg   <= deb_next;
      pend_reg  <= pend_next;
      ptype_reg <= ptype_next;
      for (int i = 0; i < N_BTN; i++) cnt_reg[i] <= cnt_next[i];
    end
  end

  // Scan downward so the candidate nearest ptr+1 is the last one to win.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = N_BTN; k >= 1; k--) begin
      cand = IDW'((int'(ptr_reg) + k) % N_BTN);
      if (pend_reg[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign load = !evt_valid_reg && gnt_any;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      evt_valid_reg <= 1'b0;
      evt_id_reg    <= '0;
      evt_press_reg <= 1'b0;
      ptr_reg       <= '0;
      overrun_reg   <= 1'b0;
    end else begin
      if (load) begin
        evt_valid_reg <= 1'b1;
        evt_id_reg    <= gnt_idx;
        evt_press_reg <= ptype_reg[gnt_idx];
        ptr_reg       <= gnt_idx;
      end else if (evt_valid_reg && evt_ready) begin
        evt_valid_reg <= 1'b0;
      end
      if (clear_overrun)
        overrun_reg <= 1'b0;
      else if (|ovr_set)
        overrun_reg <= 1'b1;
    end
  end

  assign debounced = deb_reg;
  assign evt_valid = evt_valid_reg;
  assign evt_id    = evt_id_reg;
  assign evt_press = evt_press_reg;
  assign overrun   = overrun_reg;

endmodule

// File: tb/tb_button_bank_scheduler.sv
// Directed bench for button_bank_scheduler: expected events are queued when a
// button is driven and checked in order as the event port hands them over.
module tb_button_bank_scheduler;

  logic       clk;
  logic       reset_n;
  logic       enable;
  logic [3:0] noisy;
  logic [3:0] debounced;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_id;
  logic       evt_press;
  logic       overrun;
  logic       clear_overrun;

  typedef struct packed {
    logic [1:0] id;
    logic       press;
  } evt_t;

  evt_t exp_q[$];
  evt_t mon_e;
  int   checks = 0;
  int   errors = 0;

  button_bank_scheduler #(
    .N_BTN(4),
    .TICK_DIV(9),
    .STABLE_TICKS(3)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .noisy(noisy),
    .debounced(debounced),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_id(evt_id),
    .evt_press(evt_press),
    .overrun(overrun),
    .clear_overrun(clear_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] id, input logic press);
    evt_t e;
    e.id    = id;
    e.press = press;
    exp_q.push_back(e);
  endtask

  task automatic wait_deb(input string tag, input int ch, input logic val, input int lim, output int n);
    n = 0;
    while (debounced[ch] !== val && n < lim) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, debounced[ch]}, {31'd0, val});
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || evt_valid) && n < 120) begin
      @(negedge clk);
      n++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  // Scoreboard monitor: one line per accepted event.
  always begin
    @(negedge clk);
    #1;
    if (reset_n && evt_valid && evt_ready) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_event: observed id=%0d press=%0d expected none", evt_id, evt_press);
      end
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        $display("event id=%0d press=%0d (expected id=%0d press=%0d)", evt_id, evt_press, mon_e.id, mon_e.press);
        check("evt_id", {30'd0, evt_id}, {30'd0, mon_e.id});
        check("evt_press", {31'd0, evt_press}, {31'd0, mon_e.press});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   n;
    logic seen_v;
    logic seen_d;

    reset_n       = 1'b0;
    enable        = 1'b1;
    noisy         = 4'b0000;
    evt_ready     = 1'b1;
    clear_overrun = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_debounced", {28'd0, debounced}, 32'd0);
    check("rst_evt_valid", {31'd0, evt_valid}, 32'd0);
    check("rst_evt_id", {30'd0, evt_id}, 32'd0);
    check("rst_evt_press", {31'd0, evt_press}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: clean press/release on channel 2
    noisy[2] = 1'b1;
    push(2'd2, 1'b1);
    wait_deb("t1_press_deb", 2, 1'b1, 40, n);
    check("t1_latency_in_range", {31'd0, (n >= 23 && n <= 33)}, 32'd1);
    drain("t1_press_drain");
    noisy[2] = 1'b0;
    push(2'd2, 1'b0);
    wait_deb("t1_release_deb", 2, 1'b0, 40, n);
    drain("t1_release_drain");

    // 2: bouncing input never settles
    seen_v = 1'b0;
    seen_d = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (i % 7 == 0) noisy[0] = ~noisy[0];
      @(negedge clk);
      if (evt_valid) seen_v = 1'b1;
      if (debounced[0]) seen_d = 1'b1;
    end
    noisy[0] = 1'b0;
    repeat (40) @(negedge clk);
    check("t2_no_debounce", {31'd0, seen_d}, 32'd0);
    check("t2_no_event", {31'd0, seen_v}, 32'd0);

    // 3: move ptr to 3, then two full bursts drain 0,1,2,3
    noisy[3] = 1'b1;
    push(2'd3, 1'b1);
    wait_deb("t3_ch3_deb", 3, 1'b1, 40, n);
    drain("t3_ch3_press_drain");
    noisy[3] = 1'b0;
    push(2'd3, 1'b0);
    wait_deb("t3_ch3_rel_deb", 3, 1'b0, 40, n);
    drain("t3_ch3_rel_drain");
    noisy = 4'b1111;
    for (int i = 0; i < 4; i++) push(2'(i), 1'b1);
    drain("t3_burst_press_drain");
    check("t3_deb_all", {28'd0, debounced}, 32'hF);
    noisy = 4'b0000;
    for (int i = 0; i < 4; i++) push(2'(i), 1'b0);
    drain("t3_burst_release_drain");

    // 4: stalled consumer, channel 1 press overwritten by release
    evt_ready = 1'b0;
    noisy[0]  = 1'b1;
    push(2'd0, 1'b1);
    wait_deb("t4_ch0_deb", 0, 1'b1, 40, n);
    repeat (2) @(negedge clk);
    check("t4_slot_valid", {31'd0, evt_valid}, 32'd1);
    check("t4_slot_id", {30'd0, evt_id}, 32'd0);
    noisy[1] = 1'b1;
    wait_deb("t4_ch1_press_deb", 1, 1'b1, 40, n);
    noisy[1] = 1'b0;
    wait_deb("t4_ch1_rel_deb", 1, 1'b0, 40, n);
    @(negedge clk);
    check("t4_overrun_set", {31'd0, overrun}, 32'd1);
    check("t4_stall_id", {30'd0, evt_id}, 32'd0);
    check("t4_stall_press", {31'd0, evt_press}, 32'd1);
    push(2'd1, 1'b0);
    clear_overrun = 1'b1;
    @(negedge clk);
    clear_overrun = 1'b0;
    check("t4_overrun_clear", {31'd0, overrun}, 32'd0);
    evt_ready = 1'b1;
    drain("t4_drain");
    noisy[0] = 1'b0;
    push(2'd0, 1'b0);
    drain("t4_ch0_release_drain");

    // 5: enable low freezes debouncing
    enable   = 1'b0;
    noisy[1] = 1'b1;
    repeat (100) @(negedge clk);
    check("t5_hold_deb", {31'd0, debounced[1]}, 32'd0);
    enable = 1'b1;
    push(2'd1, 1'b1);
    wait_deb("t5_flip", 1, 1'b1, 45, n);
    check("t5_latency_in_range", {31'd0, (n >= 30 && n <= 40)}, 32'd1);
    drain("t5_press_drain");
    noisy[1] = 1'b0;
    push(2'd1, 1'b0);
    drain("t5_release_drain");

    // 6: reset while an event is presented and another is pending
    evt_ready = 1'b0;
    noisy     = 4'b1100;
    n = 0;
    while (!evt_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("t6_presented_id", {30'd0, evt_id}, 32'd2);
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check("t6_rst_valid", {31'd0, evt_valid}, 32'd0);
    check("t6_rst_deb", {28'd0, debounced}, 32'd0);
    check("t6_rst_id", {30'd0, evt_id}, 32'd0);
    noisy = 4'b0000;
    @(negedge clk);
    reset_n   = 1'b1;
    evt_ready = 1'b1;
    seen_v = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (evt_valid) seen_v = 1'b1;
    end
    check("t6_no_event_after_reset", {31'd0, seen_v}, 32'd0);
    noisy[3] = 1'b1;
    push(2'd3, 1'b1);
    drain("t6_new_press_drain");
    noisy[3] = 1'b0;
    push(2'd3, 1'b0);
    drain("t6_new_release_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
